// File: rtl/axis_uart_pkg.sv
// Shared types and helpers for the UART-side AXI-Stream packet arbiter.
package axis_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } arb_state_t;

    localparam int BYTE_W = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_uart_pkt_arbiter_rr_pick.sv
// Rotate-priority encoder: first requester after last_grant, with wrap-around.
module rr_pick
    import axis_uart_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   pick,
    output logic               any_req
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest candidate to the nearest so the source right after last_grant wins.
    always_comb begin
        pick     = '0;
        any_req  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand     = (int'(last_grant) + k) % NUM_SRC;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                pick    = cand_idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_uart_pkt_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART transmit AXI-Stream port.
// The grant is held from the first beat to the end of packet, an optional idle gap
// follows each packet, and a beat watchdog force-terminates runaway packets.
module axis_uart_pkt_arbiter
    import axis_uart_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_BITS  = BYTE_W,
    parameter int GAP_CYCLES = 0,
    parameter int MAX_BEATS  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC*DATA_BITS-1:0] s_data,
    input  logic [NUM_SRC-1:0]           s_valid,
    input  logic [NUM_SRC-1:0]           s_last,
    output logic [NUM_SRC-1:0]           s_ready,
    output logic [DATA_BITS-1:0]         m_data,
    output logic                         m_valid,
    output logic                         m_last,
    input  logic                         m_ready,
    output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
    output logic                         busy,
    output logic                         err_trunc
);

    localparam int IDX_W    = idx_w(NUM_SRC);
    localparam int BEAT_W   = $clog2(MAX_BEATS + 1);
    localparam int GAP_W    = idx_w(GAP_CYCLES);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    arb_state_t           state;
    arb_state_t           state_next;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     pick;
    logic                 pick_any;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 at_limit;
    logic                 xfer;
    logic                 trunc;
    logic [DATA_BITS-1:0] src_data [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = s_data[i*DATA_BITS +: DATA_BITS];
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (s_valid),
        .last_grant (last_grant),
        .pick       (pick),
        .any_req    (pick_any)
    );

    // Watchdog: the beat that would reach MAX_BEATS is forced to be the last one.
    assign at_limit = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus zero-latency pass-through of the granted source while BUSY.
    always_comb begin
        state_next = state;
        s_ready    = '0;
        m_data     = '0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        xfer       = 1'b0;
        trunc      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                m_data             = src_data[grant_idx];
                m_valid            = s_valid[grant_idx];
                m_last             = s_last[grant_idx] | at_limit;
                s_ready[grant_idx] = m_ready;
                xfer               = m_valid & m_ready;
                if (xfer && m_last) begin
                    trunc      = at_limit & ~s_last[grant_idx];
                    state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant capture, beat and gap counters, truncation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_SRC - 1);
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            err_trunc  <= 1'b0;
        end else begin
            err_trunc <= trunc;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_idx  <= pick;
                        last_grant <= pick;
                        beat_cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        gap_cnt  <= GAP_W'(GAP_LOAD);
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_pkt_arbiter.sv
// Randomized self-checking bench for axis_uart_pkt_arbiter with a queue-based reference model.
module tb_axis_uart_pkt_arbiter;

    localparam int NUM  = 4;
    localparam int DW   = 8;
    localparam int GAP  = 3;
    localparam int MAXB = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM*DW-1:0] s_data;
    logic [NUM-1:0]    s_valid;
    logic [NUM-1:0]    s_last;
    logic [NUM-1:0]    s_ready;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic [1:0]        grant_idx;
    logic              busy;
    logic              err_trunc;

    axis_uart_pkt_arbiter #(
        .NUM_SRC    (NUM),
        .DATA_BITS  (DW),
        .GAP_CYCLES (GAP),
        .MAX_BEATS  (MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .grant_idx (grant_idx),
        .busy      (busy),
        .err_trunc (err_trunc)
    );

    always #5 clk = ~clk;

    // Reference model: per-source byte queues {last, data} and packet bookkeeping.
    logic [DW:0] srcq [NUM][$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  in_pkt = 0;
    int  exp_src = 0;
    int  last_g = NUM - 1;
    int  beats = 0;
    bit  err_pend = 0;
    int  post = 0;
    int  cyc = 0;
    int  end_cyc = 0;
    int  gap_seen = 0;
    int  trunc_pulses = 0;
    int  pkt_ends = 0;
    int  grant_log[$];
    int  rdy_mode = 0;
    bit  drop_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM; i++) if (srcq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int next_src(input int last);
        for (int k = 1; k <= NUM; k++) if (srcq[(last + k) % NUM].size() != 0) return (last + k) % NUM;
        return -1;
    endfunction

    task automatic push_pkt(input int src, input int len, input int base);
        logic [DW-1:0] d;
        for (int j = 0; j < len; j++) begin
            d = (base < 0) ? DW'($urandom) : DW'(base + j);
            srcq[src].push_back({(j == len - 1), d});
        end
    endtask

    task automatic model_reset();
        in_pkt   = 0;
        exp_src  = 0;
        last_g   = NUM - 1;
        beats    = 0;
        err_pend = 0;
        post     = 0;
    endtask

    task automatic monitor_cycle();
        logic [DW:0] b;
        bit          any_q;
        bit          exp_last;
        int          s;
        any_q = pending();
        chk("s_ready_onehot0", $onehot0(s_ready), 1);
        chk("err_trunc", err_trunc, err_pend);
        if (err_trunc) trunc_pulses++;
        err_pend = 0;
        if (post != 0) begin
            if (post <= GAP) begin
                chk("gap_busy", busy, 1);
                chk("gap_m_valid", m_valid, 0);
                chk("gap_s_ready", s_ready, 0);
            end else if (post == GAP + 1) begin
                chk("idle_busy", busy, 0);
                chk("idle_m_valid", m_valid, 0);
                chk("idle_s_ready", s_ready, 0);
            end else begin
                chk("arb_busy", busy, any_q);
            end
            post = (post == GAP + 2) ? 0 : post + 1;
        end else if (!in_pkt && !any_q) begin
            chk("rest_busy", busy, 0);
            chk("rest_m_valid", m_valid, 0);
        end
        if (in_pkt) begin
            chk("pkt_s_ready", s_ready, 32'(m_ready) << exp_src);
            chk("pkt_grant", grant_idx, exp_src);
        end
        if (m_valid && m_ready) begin
            if (!in_pkt) begin
                s = next_src(last_g);
                if (s < 0) begin
                    chk("unexpected_beat", 1, 0);
                    return;
                end
                exp_src  = s;
                last_g   = s;
                in_pkt   = 1;
                beats    = 0;
                gap_seen = cyc - end_cyc;
                grant_log.push_back(s);
                chk("first_grant", grant_idx, s);
                chk("first_s_ready", s_ready, 32'(1) << s);
            end
            if (srcq[exp_src].size() == 0) begin
                chk("beat_without_data", 1, 0);
                return;
            end
            b = srcq[exp_src][0];
            beats++;
            exp_last = b[DW] || (beats == MAXB);
            chk("m_data", m_data, b[DW-1:0]);
            chk("m_last", m_last, exp_last);
            void'(srcq[exp_src].pop_front());
            if (exp_last) begin
                in_pkt   = 0;
                err_pend = !b[DW];
                post     = 1;
                end_cyc  = cyc;
                pkt_ends++;
            end
        end
    endtask

    // Monitor: sample outputs on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) model_reset();
            else monitor_cycle();
        end
    end

    // Driver: present queue heads and m_ready shortly after each rising edge.
    initial begin
        s_data  = '0;
        s_valid = '0;
        s_last  = '0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM; i++) begin
                if (srcq[i].size() != 0) begin
                    s_data[i*DW +: DW] = srcq[i][0][DW-1:0];
                    s_last[i]          = srcq[i][0][DW];
                    s_valid[i]         = 1'b1;
                end else begin
                    s_data[i*DW +: DW] = '0;
                    s_last[i]          = 1'b0;
                    s_valid[i]         = 1'b0;
                end
                if (drop_en && in_pkt && i == exp_src && $urandom_range(0, 3) == 0) s_valid[i] = 1'b0;
            end
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((pending() || in_pkt || post != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_done", (n < budget), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_grant_idx"}, grant_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err_trunc"}, err_trunc, 0);
    endtask

    initial begin
        int l0;
        int t0;
        int e0;
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // Single packet from source 2; last beat coincides with the beat limit.
        @(negedge clk);
        #1;
        t0 = trunc_pulses;
        e0 = pkt_ends;
        push_pkt(2, 5, 'h41);
        @(negedge clk);
        #1;
        chk("lat_idle_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("lat_busy", busy, 1);
        chk("lat_grant", grant_idx, 2);
        chk("lat_m_valid", m_valid, 1);
        wait_drain(200);
        chk("single_trunc", trunc_pulses - t0, 0);
        chk("single_pkts", pkt_ends - e0, 1);

        // Contention: every source holds two 2-beat packets.
        l0 = last_g;
        grant_log.delete();
        for (int s = 0; s < NUM; s++) begin
            push_pkt(s, 2, -1);
            push_pkt(s, 2, -1);
        end
        wait_drain(500);
        chk("rr_count", grant_log.size(), 2 * NUM);
        for (int j = 0; j < grant_log.size() && j < 2 * NUM; j++) chk("rr_order", grant_log[j], (l0 + 1 + j) % NUM);

        // Backpressure: m_ready toggles every cycle during a source 1 packet.
        rdy_mode = 1;
        push_pkt(1, 6, -1);
        wait_drain(300);
        rdy_mode = 0;

        // Truncation: 7 beats with MAX_BEATS=5 become a 5-beat and a 2-beat packet.
        t0 = trunc_pulses;
        e0 = pkt_ends;
        push_pkt(0, 7, 'h60);
        wait_drain(300);
        chk("trunc_pulses", trunc_pulses - t0, 1);
        chk("trunc_pkts", pkt_ends - e0, 2);

        // Gap: two back-to-back packets from source 3.
        push_pkt(3, 3, -1);
        push_pkt(3, 3, -1);
        wait_drain(300);
        chk("gap_spacing", gap_seen, GAP + 2);

        // Randomized traffic with random backpressure and mid-packet valid drops.
        rdy_mode = 2;
        drop_en  = 1;
        for (int r = 0; r < 25; r++) begin
            for (int s = 0; s < NUM; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    n = $urandom_range(1, 2);
                    for (int p = 0; p < n; p++) push_pkt(s, $urandom_range(1, 8), -1);
                end
            end
            wait_drain(4000);
        end
        drop_en  = 0;
        rdy_mode = 0;

        // Reset asserted during beat 2 of a packet.
        push_pkt(2, 5, -1);
        n = 0;
        while (!(in_pkt && beats == 1) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_pkt_reached", (n < 100), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        for (int i = 0; i < NUM; i++) srcq[i].delete();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        grant_log.delete();
        for (int s = 0; s < NUM; s++) push_pkt(s, 2, -1);
        wait_drain(500);
        chk("post_rst_count", grant_log.size(), NUM);
        for (int j = 0; j < grant_log.size() && j < NUM; j++) chk("post_rst_order", grant_log[j], j);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
